// File: rtl/test005.sv
// Shared fill/readback/sum engine behind run() and test() req/busy method ports; busy spans 2N+3 cycles,
// test wins simultaneous requests, a losing req waits (not dropped) until the engine returns to IDLE.
module test005 #(
    parameter int          N        = 16,
    parameter logic [31:0] EXPECTED = 32'd376
) (
    input  logic clk,
    input  logic reset,
    input  logic run_req,
    output logic run_busy,
    input  logic test_req,
    output logic test_busy,
    output logic test_return
);

    localparam int IW = $clog2(N + 1);
    localparam int AW = $clog2(N);
    localparam logic [IW-1:0] WR_LAST = IW'(N - 1);
    localparam logic [IW-1:0] RD_LAST = IW'(N);

    typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [AW-1:0] addr;
    logic [31:0]   acc;
    logic [31:0]   pat;
    logic [31:0]   rdata;
    logic          owner_test;
    logic [31:0]   mem [N];

    assign addr = idx[AW-1:0];

    // Storage has no reset; its contents are rewritten before every readback.
    always_ff @(posedge clk) begin
        if (state == WRITE)
            mem[addr] <= pat;
        if (state == READ && idx != RD_LAST)
            rdata <= mem[addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            pat         <= '0;
            owner_test  <= 1'b0;
            run_busy    <= 1'b0;
            test_busy   <= 1'b0;
            test_return <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    acc <= '0;
                    pat <= 32'd1;
                    if (test_req) begin
                        owner_test <= 1'b1;
                        test_busy  <= 1'b1;
                        state      <= WRITE;
                    end else if (run_req) begin
                        owner_test <= 1'b0;
                        run_busy   <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    // pat tracks 3*idx+1 without a multiplier
                    pat <= pat + 32'd3;
                    if (idx == WR_LAST) begin
                        idx   <= '0;
                        state <= READ;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                READ: begin
                    // rdata lags the address by one cycle, so accumulation trails by one
                    if (idx != '0)
                        acc <= acc + rdata;
                    if (idx == RD_LAST)
                        state <= CHECK;
                    else
                        idx <= idx + 1'b1;
                end
                CHECK: begin
                    if (owner_test)
                        test_return <= (acc == EXPECTED);
                    state <= DONE;
                end
                DONE: begin
                    run_busy  <= 1'b0;
                    test_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test005.sv
// Directed bench for test005: call-level model checked every cycle plus literal expectations.
module tb_test005;

    localparam int          N_MAIN   = 16;
    localparam logic [31:0] EXP_MAIN = 32'd376;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run_req = 1'b0, test_req = 1'b0;
    logic run_busy, test_busy, test_return;
    logic run_req_b = 1'b0, test_req_b = 1'b0, run_busy_b, test_busy_b, test_return_b;
    logic run_req_c = 1'b0, test_req_c = 1'b0, run_busy_c, test_busy_c, test_return_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    test005 dut (
        .clk(clk), .reset(reset),
        .run_req(run_req), .run_busy(run_busy),
        .test_req(test_req), .test_busy(test_busy), .test_return(test_return)
    );

    test005 #(.N(16), .EXPECTED(32'd377)) dut_b (
        .clk(clk), .reset(reset),
        .run_req(run_req_b), .run_busy(run_busy_b),
        .test_req(test_req_b), .test_busy(test_busy_b), .test_return(test_return_b)
    );

    test005 #(.N(4), .EXPECTED(32'd22)) dut_c (
        .clk(clk), .reset(reset),
        .run_req(run_req_c), .run_busy(run_busy_c),
        .test_req(test_req_c), .test_busy(test_busy_c), .test_return(test_return_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pattern_sum(input int n);
        logic [31:0] s = 0;
        for (int i = 0; i < n; i++)
            s = s + 32'(3 * i + 1);
        return s;
    endfunction

    // Call-level model of the main instance: a call occupies 2N+3 cycles after
    // acceptance, its verdict appears on its last busy cycle, calls start only from idle.
    int m_remain = 0;
    bit m_owner_test = 0;
    bit m_ret = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_remain = 0;
            m_owner_test = 0;
            m_ret = 0;
        end else if (m_remain == 0) begin
            if (test_req) begin
                m_remain = 2 * N_MAIN + 3;
                m_owner_test = 1;
            end else if (run_req) begin
                m_remain = 2 * N_MAIN + 3;
                m_owner_test = 0;
            end
        end else begin
            m_remain--;
            if (m_remain == 1 && m_owner_test)
                m_ret = (pattern_sum(N_MAIN) == EXP_MAIN);
        end
    end

    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            #1;
            chk("model_run_busy", {31'd0, run_busy}, {31'd0, (m_remain > 0 && !m_owner_test)});
            chk("model_test_busy", {31'd0, test_busy}, {31'd0, (m_remain > 0 && m_owner_test)});
            chk("model_test_return", {31'd0, test_return}, {31'd0, m_ret});
            chk("busy_exclusive", {31'd0, run_busy & test_busy}, 32'd0);
        end
    end

    function automatic logic busy_of(input int sel);
        case (sel)
            0: return run_busy;
            1: return test_busy;
            2: return test_busy_b;
            default: return test_busy_c;
        endcase
    endfunction

    // Waits (bounded) for busy to rise, then counts busy cycles; returns on the first idle negedge.
    task automatic measure(input int sel, output int cyc);
        for (int t = 0; t < 10 && !busy_of(sel); t++)
            @(negedge clk);
        cyc = 0;
        while (busy_of(sel) && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int sel);
        for (int t = 0; t < 100 && busy_of(sel); t++)
            @(negedge clk);
        chk("idle_timeout", {31'd0, busy_of(sel)}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_run_busy", {31'd0, run_busy}, 32'd0);
        chk("rst_test_busy", {31'd0, test_busy}, 32'd0);
        chk("rst_test_return", {31'd0, test_return}, 32'd0);

        // run pulse: result discarded
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        chk("run_busy_rise", {31'd0, run_busy}, 32'd1);
        measure(0, cyc);
        chk("run_busy_len", cyc, 32'd35);
        chk("run_keeps_return", {31'd0, test_return}, 32'd0);
        @(negedge clk);

        // test held high: completes, one idle cycle, restarts
        test_req = 1'b1;
        measure(1, cyc);
        chk("test_busy_len", cyc, 32'd35);
        chk("test_return_pass", {31'd0, test_return}, 32'd1);
        @(negedge clk);
        chk("test_restart", {31'd0, test_busy}, 32'd1);
        chk("return_hold_restart", {31'd0, test_return}, 32'd1);
        test_req = 1'b0;
        wait_idle(1);

        // simultaneous requests: test first, run after one idle cycle
        run_req = 1'b1;
        test_req = 1'b1;
        @(negedge clk);
        chk("prio_test_busy", {31'd0, test_busy}, 32'd1);
        chk("prio_run_busy", {31'd0, run_busy}, 32'd0);
        test_req = 1'b0;
        measure(1, cyc);
        chk("prio_test_len", cyc, 32'd35);
        chk("prio_gap_run", {31'd0, run_busy}, 32'd0);
        @(negedge clk);
        chk("pending_run_accept", {31'd0, run_busy}, 32'd1);
        run_req = 1'b0;
        wait_idle(0);

        // reset on the 10th busy cycle aborts the call
        test_req = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        chk("abort_pre_busy", {31'd0, test_busy}, 32'd1);
        reset = 1'b0;
        test_req = 1'b0;
        #1;
        chk("abort_busy", {31'd0, test_busy}, 32'd0);
        chk("abort_return", {31'd0, test_return}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_req = 1'b1;
        measure(1, cyc);
        chk("post_abort_len", cyc, 32'd35);
        chk("post_abort_return", {31'd0, test_return}, 32'd1);
        test_req = 1'b0;
        wait_idle(1);

        // mismatching EXPECTED, then a short N=4 instance
        test_req_b = 1'b1;
        measure(2, cyc);
        chk("b_busy_len", cyc, 32'd35);
        chk("b_return_fail", {31'd0, test_return_b}, 32'd0);
        test_req_b = 1'b0;
        wait_idle(2);

        test_req_c = 1'b1;
        measure(3, cyc);
        chk("c_busy_len", cyc, 32'd11);
        chk("c_return_pass", {31'd0, test_return_c}, 32'd1);
        test_req_c = 1'b0;
        wait_idle(3);
        chk("c_run_busy_idle", {31'd0, run_busy_c}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
